ahb_lsu_master: RTL and testbench
=================================

Name: ahb_lsu_master

Overview:
- Load/store execution block that consumes the memory-operation outputs of the ARM standard decoder and drives an AHB-Lite master port.
- Supported operations: LDR/STR, LDRH/STRH, LDRSB/LDRSH and SWP/SWPB.
- The block runs one transfer at a time and stalls the core through req_ready.
- It returns load data to the register writeback path with sign or zero extension and byte-lane alignment applied.

Parameters:
- ADDR_W, 32, width of HADDR and of the address inputs.
- DATA_W, 32, bus data width. The only supported value is 32.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request strobe. Accepted only when req_ready=1.
- req_ready  out  1  block is idle and can accept a request.
- req_wr  in  1  store (decoder AHB_wr_en).
- req_rd  in  1  load (decoder AHB_rd_en). req_wr=1 with req_rd=1 means swap.
- req_size  in  2  00=word, 10=halfword, 11=byte. 01 is treated as word.
- req_pre  in  1  1: transfer address is req_addr_calc (pre-index). 0: transfer address is req_addr_base (post-index).
- req_sext  in  1  sign-extend load data (decoder AHB_ldrs_s).
- req_addr_base  in  32  base register value (Rn).
- req_addr_calc  in  32  ALU result, base plus or minus offset.
- req_wdata  in  32  store data or swap source.
- req_rd_id  in  5  destination register id for load data.
- wb_valid  out  1  one-cycle pulse carrying load result.
- wb_id  out  5  destination id.
- wb_data  out  32  aligned and extended load data.
- abort  out  1  one-cycle data-abort pulse.
- HADDR  out  32  AHB address.
- HTRANS  out  2  AHB transfer type. Only IDLE (00) and NONSEQ (10) are used.
- HWRITE  out  1  AHB write/read select.
- HSIZE  out  3  000=byte, 001=half, 010=word.
- HMASTLOCK  out  1  locked-transfer indication, asserted for swap.
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  AHB transfer-done / wait control.
- HRESP  in  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset values, all registered outputs:
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HMASTLOCK=0, HWDATA=0.
  - wb_valid=0, wb_id=0, wb_data=0, abort=0.
  - req_ready=1, state=IDLE.
- Reset mid-transfer: the next edge forces IDLE and HTRANS=00. No writeback and no abort are produced.
- States are IDLE, ADDR, DATA, SWP_ADDR, SWP_DATA, ERR.
- IDLE:
  - req_ready=1.
  - When req_valid is high, latch the request at edge N.
  - A request with req_rd=0 and req_wr=0 is accepted and ignored.
- ADDR (from cycle N+1):
  - Drive HTRANS=NONSEQ, HADDR, HSIZE.
  - HWRITE = req_wr AND NOT req_rd.
  - HMASTLOCK = swap.
  - Hold all of these until HREADY=1, then go to DATA.
- DATA:
  - HTRANS=IDLE.
  - For a store, HWDATA carries the replicated data: byte replicated ×4, half ×2.
  - Wait while HREADY=0 and HRESP=0.
  - On HREADY=1 with HRESP=0:
    - Load: register wb_valid/wb_id/wb_data, go to IDLE.
    - Store: go to IDLE.
    - Swap: capture read data, go to SWP_ADDR.
- Zero-wait latency: load wb_valid and req_ready return together at cycle N+3.
- Swap:
  - SWP_ADDR issues a write to the same address. SWP_DATA drives req_wdata.
  - HMASTLOCK stays high from the first ADDR cycle through the last SWP_DATA cycle.
  - wb_valid carries the read value only after the write completes.
- Error response: HRESP=1 in DATA or SWP_DATA goes to ERR.
  - ERR waits for HREADY=1, which is the second cycle of the AHB two-cycle error response.
  - abort then pulses for 1 cycle and the state returns to IDLE.
  - No writeback is produced. A pending swap write is cancelled and HMASTLOCK drops.
- Load alignment:
  - Byte lane is HRDATA[8*a+7:8*a] with a = addr[1:0].
  - Halfword is HRDATA[16*addr[1]+15:16*addr[1]].
  - Zero-extend when req_sext=0, sign-extend when req_sext=1.
  - req_sext with a word size is ignored.
- req_valid while not ready is ignored. The upstream holds the request.

Optional Feature:
- Macro name: AHB_LSU_ALIGN_CHECK_EN.
- Defined:
  - Word access with addr[1:0]≠0, or halfword with addr[0]=1, issues no bus transfer.
  - abort pulses at cycle N+1 and req_ready returns at N+2.
- Undefined:
  - The address is issued as-is. The halfword lane is chosen by addr[1] only.

Decomposition:
- Package ahb_lsu_pkg holds:
  - HTRANS constants IDLE/NONSEQ.
  - HSIZE constants BYTE/HALF/WORD.
  - req_size encodings SZ_WORD/SZ_HALF/SZ_BYTE.
  - State enum.
- One combinational sub-module, lsu_data_align:
  - Read lane extraction with extension.
  - Write lane replication.
  - Size-to-HSIZE mapping.

Test Plan:
- Word load, pre-index, calc=0x100, HRDATA=0xDEADBEEF, zero wait → HTRANS=NONSEQ at N+1, HADDR=0x100; wb_valid at N+3 with wb_data=0xDEADBEEF.
- LDRSB post-index, base=0x203, HRDATA=0x80FFFFFF, 2 wait states → HADDR=0x203, HSIZE=000, wb_data=0xFFFFFF80, wb_valid at N+5.
- STRB, wdata=0x000000A5 → HWRITE=1, HWDATA=0xA5A5A5A5; no wb_valid.
- SWP word at 0x40, read 0x11, wdata 0x22 → read then write to 0x40 with HMASTLOCK continuous; wb_data=0x11 after write.
- Load with HRESP=1 for 2 cycles (HREADY 0 then 1) → abort pulse, no wb_valid, req_ready=1 next cycle.
- rst=1 asserted in DATA → HTRANS=00 and state IDLE next cycle.
- With AHB_LSU_ALIGN_CHECK_EN: word load at 0x102 → abort pulse and no bus transfer.

Source files
------------

// File: rtl/ahb_lsu_pkg.sv
// Shared encodings for the AHB-Lite load/store master: bus constants,
// decoder size codes and the transfer state machine states.
package ahb_lsu_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_BYTE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_SWP_ADDR,
      ST_SWP_DATA,
      ST_ERR
   } lsu_state_t;

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for the load/store master: read lane extraction with
// sign/zero extension, write data replication and size-to-HSIZE mapping.
module lsu_data_align
   import ahb_lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata_ext,
   output logic [DATA_W-1:0] wdata_rep,
   output logic [2:0]        hsize
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Halfword lane follows addr[1] only; addr[0] never shifts the halfword.
   assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
   assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      rdata_ext = rdata;
      wdata_rep = wdata;
      hsize     = HSIZE_WORD;
      case (size)
         SZ_BYTE: begin
            rdata_ext = {{24{sext & rd_byte[7]}}, rd_byte};
            wdata_rep = {4{wdata[7:0]}};
            hsize     = HSIZE_BYTE;
         end
         SZ_HALF: begin
            rdata_ext = {{16{sext & rd_half[15]}}, rd_half};
            wdata_rep = {2{wdata[15:0]}};
            hsize     = HSIZE_HALF;
         end
         default: begin
            rdata_ext = rdata;
            wdata_rep = wdata;
            hsize     = HSIZE_WORD;
         end
      endcase
   end

endmodule

// File: rtl/ahb_lsu_master.sv
// Single-outstanding AHB-Lite load/store/swap master fed by the ARM decoder.
// Define AHB_LSU_ALIGN_CHECK_EN to abort misaligned word/halfword accesses.
module ahb_lsu_master
   import ahb_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic              req_rd,
   input  logic [1:0]        req_size,
   input  logic              req_pre,
   input  logic              req_sext,
   input  logic [ADDR_W-1:0] req_addr_base,
   input  logic [ADDR_W-1:0] req_addr_calc,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [4:0]        req_rd_id,
   output logic              wb_valid,
   output logic [4:0]        wb_id,
   output logic [DATA_W-1:0] wb_data,
   output logic              abort,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic              HMASTLOCK,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   lsu_state_t state, state_nxt;

   logic              wr_q, rd_q, sext_q, misalign_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [4:0]        id_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

   logic [ADDR_W-1:0] addr_sel;
   logic              misalign;
   logic              swap, load, store;
   logic [DATA_W-1:0] rdata_ext, wdata_rep;
   logic [2:0]        hsize;

   assign addr_sel = req_pre ? req_addr_calc : req_addr_base;
   assign swap     = wr_q & rd_q;
   assign load     = rd_q & ~wr_q;
   assign store    = wr_q & ~rd_q;

`ifdef AHB_LSU_ALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      if (req_rd | req_wr) begin
         if (req_size == SZ_HALF)
            misalign = addr_sel[0];
         else if (req_size != SZ_BYTE)
            misalign = |addr_sel[1:0];
      end
   end
`else
   assign misalign = 1'b0;
`endif

   lsu_data_align #(.DATA_W(DATA_W)) u_align (
      .size      (size_q),
      .sext      (sext_q),
      .addr_lo   (addr_q[1:0]),
      .rdata     (HRDATA),
      .wdata     (wdata_q),
      .rdata_ext (rdata_ext),
      .wdata_rep (wdata_rep),
      .hsize     (hsize)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (req_valid) begin
               if (misalign)              state_nxt = ST_ERR;
               else if (req_rd | req_wr)  state_nxt = ST_ADDR;
            end
         ST_ADDR:
            if (HREADY) state_nxt = ST_DATA;
         ST_DATA:
            if (HRESP)       state_nxt = ST_ERR;
            else if (HREADY) state_nxt = swap ? ST_SWP_ADDR : ST_IDLE;
         ST_SWP_ADDR:
            if (HREADY) state_nxt = ST_SWP_DATA;
         ST_SWP_DATA:
            if (HRESP)       state_nxt = ST_ERR;
            else if (HREADY) state_nxt = ST_IDLE;
         // Alignment aborts never reached the bus, so they skip the HREADY wait.
         ST_ERR:
            if (misalign_q | HREADY) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == ST_IDLE);
      HADDR     = addr_q;
      HTRANS    = HTRANS_IDLE;
      HWRITE    = 1'b0;
      HSIZE     = HSIZE_BYTE;
      HMASTLOCK = 1'b0;
      HWDATA    = '0;
      case (state)
         ST_ADDR: begin
            HTRANS    = HTRANS_NONSEQ;
            HWRITE    = store;
            HSIZE     = hsize;
            HMASTLOCK = swap;
         end
         ST_DATA: begin
            HMASTLOCK = swap;
            if (store) HWDATA = wdata_rep;
         end
         ST_SWP_ADDR: begin
            HTRANS    = HTRANS_NONSEQ;
            HWRITE    = 1'b1;
            HSIZE     = hsize;
            HMASTLOCK = 1'b1;
         end
         ST_SWP_DATA: begin
            HMASTLOCK = 1'b1;
            HWDATA    = wdata_rep;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid   <= 1'b0;
         wb_id      <= '0;
         wb_data    <= '0;
         abort      <= 1'b0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         misalign_q <= 1'b0;
         addr_q     <= '0;
      end else begin
         wb_valid <= 1'b0;
         abort    <= 1'b0;
         if (state == ST_IDLE && req_valid) begin
            wr_q       <= req_wr;
            rd_q       <= req_rd;
            misalign_q <= misalign;
            addr_q     <= addr_sel;
            abort      <= misalign;
         end
         if (state == ST_DATA && HREADY && !HRESP && load) begin
            wb_valid <= 1'b1;
            wb_id    <= id_q;
            wb_data  <= rdata_ext;
         end
         // Swap result is held back until the locked write has completed.
         if (state == ST_SWP_DATA && HREADY && !HRESP) begin
            wb_valid <= 1'b1;
            wb_id    <= id_q;
            wb_data  <= rdata_q;
         end
         if (state == ST_ERR && !misalign_q && HREADY)
            abort <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_IDLE && req_valid) begin
         size_q  <= req_size;
         sext_q  <= req_sext;
         id_q    <= req_rd_id;
         wdata_q <= req_wdata;
      end
      if (state == ST_DATA && HREADY && !HRESP && swap)
         rdata_q <= rdata_ext;
   end

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Self-checking bench for ahb_lsu_master: directed table, hand sequences for
// reset and alignment aborts, and randomized transfers against a lane model.
module tb_ahb_lsu_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr, req_rd, req_pre, req_sext;
   logic [1:0]  req_size;
   logic [31:0] req_addr_base, req_addr_calc, req_wdata;
   logic [4:0]  req_rd_id;
   logic        wb_valid, abort;
   logic [4:0]  wb_id;
   logic [31:0] wb_data;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [2:0]  HSIZE;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ahb_lsu_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_wr(req_wr), .req_rd(req_rd), .req_size(req_size),
      .req_pre(req_pre), .req_sext(req_sext),
      .req_addr_base(req_addr_base), .req_addr_calc(req_addr_calc),
      .req_wdata(req_wdata), .req_rd_id(req_rd_id),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .abort(abort),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP)
   );

   typedef struct {
      bit          wr, rd;
      logic [1:0]  size;
      bit          pre, sext;
      logic [31:0] base, calc, wdata;
      logic [4:0]  id;
      logic [31:0] rdata;
      int          ws, ws2;
      bit          err;
      logic [31:0] exp_haddr;
      logic [2:0]  exp_hsize;
      logic [31:0] exp_hwdata;
      bit          exp_wb;
      logic [31:0] exp_wb_data;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: lane selection by shifting, replication by multiplication.
   function automatic logic [31:0] m_load(logic [1:0] size, bit sext, logic [31:0] addr, logic [31:0] rd);
      logic [31:0] v;
      if (size == 2'b11) begin
         v = (rd >> (8 * addr[1:0])) & 32'hFF;
         if (sext && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b10) begin
         v = (rd >> (16 * addr[1])) & 32'hFFFF;
         if (sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_wbus(logic [1:0] size, logic [31:0] wd);
      if (size == 2'b11) return (wd & 32'hFF) * 32'h0101_0101;
      if (size == 2'b10) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [2:0] m_hsize(logic [1:0] size);
      if (size == 2'b11) return 3'd0;
      if (size == 2'b10) return 3'd1;
      return 3'd2;
   endfunction

   function automatic vec_t mk(bit wr, bit rd, logic [1:0] size, bit pre, bit sext,
                               logic [31:0] base, logic [31:0] calc, logic [31:0] wdata,
                               logic [31:0] rdata, int ws, bit err,
                               logic [31:0] haddr, logic [2:0] hsize, logic [31:0] hwdata,
                               bit wb, logic [31:0] wbdata);
      vec_t v;
      v.wr = wr; v.rd = rd; v.size = size; v.pre = pre; v.sext = sext;
      v.base = base; v.calc = calc; v.wdata = wdata; v.rdata = rdata;
      v.id = 5'(tbl.size() + 3); v.ws = ws; v.ws2 = ws; v.err = err;
      v.exp_haddr = haddr; v.exp_hsize = hsize; v.exp_hwdata = hwdata;
      v.exp_wb = wb; v.exp_wb_data = wbdata;
      return v;
   endfunction

   // Starts one cycle after a rising edge with the DUT idle; ends the same way.
   task automatic txn(input vec_t v);
      bit store, swap;
      int c0, lat;
      store = v.wr && !v.rd;
      swap  = v.wr && v.rd;
      req_wr = v.wr; req_rd = v.rd; req_size = v.size; req_pre = v.pre;
      req_sext = v.sext; req_addr_base = v.base; req_addr_calc = v.calc;
      req_wdata = v.wdata; req_rd_id = v.id; req_valid = 1'b1;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      @(negedge clk);
      check("ready_idle", req_ready, 1);
      @(posedge clk); #1;
      c0 = cyc;
      req_valid = 1'b0;
      if (!v.wr && !v.rd) begin
         @(negedge clk);
         check("noop_htrans", HTRANS, 0);
         check("noop_ready", req_ready, 1);
         @(posedge clk); #1;
         return;
      end
      @(negedge clk);
      check("addr_htrans", HTRANS, 2);
      check("addr_haddr", HADDR, v.exp_haddr);
      check("addr_hsize", HSIZE, v.exp_hsize);
      check("addr_hwrite", HWRITE, store);
      check("addr_lock", HMASTLOCK, swap);
      check("addr_ready", req_ready, 0);
      @(posedge clk); #1;
      for (int k = 0; k < v.ws; k++) begin
         HREADY = 1'b0; HRESP = 1'b0;
         @(negedge clk);
         check("dwait_htrans", HTRANS, 0);
         check("dwait_wb", wb_valid, 0);
         if (store) check("dwait_hwdata", HWDATA, v.exp_hwdata);
         @(posedge clk); #1;
      end
      if (v.err) begin
         HREADY = 1'b0; HRESP = 1'b1;
         @(posedge clk); #1;
         HREADY = 1'b1; HRESP = 1'b1;
         @(negedge clk);
         check("err_lock", HMASTLOCK, 0);
         check("err_htrans", HTRANS, 0);
         check("err_abort_early", abort, 0);
         @(posedge clk); #1;
         HRESP = 1'b0;
         @(negedge clk);
         check("err_abort", abort, 1);
         check("err_no_wb", wb_valid, 0);
         check("err_ready", req_ready, 1);
         @(posedge clk); #1;
         @(negedge clk);
         check("err_abort_pulse", abort, 0);
         check("err_htrans_after", HTRANS, 0);
         @(posedge clk); #1;
         return;
      end
      HREADY = 1'b1; HRDATA = v.rdata;
      @(negedge clk);
      check("data_htrans", HTRANS, 0);
      check("data_lock", HMASTLOCK, swap);
      if (store) check("data_hwdata", HWDATA, v.exp_hwdata);
      @(posedge clk); #1;
      HRDATA = $urandom;
      if (swap) begin
         @(negedge clk);
         check("swp_htrans", HTRANS, 2);
         check("swp_hwrite", HWRITE, 1);
         check("swp_haddr", HADDR, v.exp_haddr);
         check("swp_hsize", HSIZE, v.exp_hsize);
         check("swp_lock", HMASTLOCK, 1);
         check("swp_no_wb", wb_valid, 0);
         @(posedge clk); #1;
         for (int k = 0; k < v.ws2; k++) begin
            HREADY = 1'b0;
            @(negedge clk);
            check("swpw_lock", HMASTLOCK, 1);
            check("swpw_hwdata", HWDATA, v.exp_hwdata);
            @(posedge clk); #1;
         end
         HREADY = 1'b1;
         @(negedge clk);
         check("swpd_lock", HMASTLOCK, 1);
         check("swpd_hwdata", HWDATA, v.exp_hwdata);
         check("swpd_no_wb", wb_valid, 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      lat = 2 + v.ws + (swap ? 2 + v.ws2 : 0);
      check("done_latency", 32'(cyc - c0), 32'(lat));
      check("done_wb_valid", wb_valid, v.exp_wb);
      if (v.exp_wb) begin
         check("done_wb_data", wb_data, v.exp_wb_data);
         check("done_wb_id", wb_id, v.id);
      end
      check("done_ready", req_ready, 1);
      check("done_lock", HMASTLOCK, 0);
      check("done_abort", abort, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("wb_pulse", wb_valid, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int op;
      logic [31:0] a;
      rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_rd = 1'b0; req_size = 2'b00;
      req_pre = 1'b0; req_sext = 1'b0; req_addr_base = '0; req_addr_calc = '0;
      req_wdata = '0; req_rd_id = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_htrans", HTRANS, 0);
      check("rst_haddr", HADDR, 0);
      check("rst_hwrite", HWRITE, 0);
      check("rst_hsize", HSIZE, 0);
      check("rst_lock", HMASTLOCK, 0);
      check("rst_hwdata", HWDATA, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_id", wb_id, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_abort", abort, 0);
      check("rst_ready", req_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      //          wr rd size  pre sx base      calc      wdata         rdata         ws err haddr     hsz hwdata        wb data
      tbl.push_back(mk(0, 1, 2'b00, 1, 0, 32'h0F0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'h100, 2, 32'h0,        1, 32'hDEADBEEF));
      tbl.push_back(mk(0, 1, 2'b11, 0, 1, 32'h203, 32'h300, 32'h0,        32'h80FFFFFF, 2, 0, 32'h203, 0, 32'h0,        1, 32'hFFFFFF80));
      tbl.push_back(mk(1, 0, 2'b11, 1, 0, 32'h0,   32'h50,  32'h000000A5, 32'h0,        0, 0, 32'h50,  0, 32'hA5A5A5A5, 0, 32'h0));
      tbl.push_back(mk(1, 1, 2'b00, 1, 0, 32'h0,   32'h40,  32'h22,       32'h11,       0, 0, 32'h40,  2, 32'h22,       1, 32'h11));
      tbl.push_back(mk(0, 1, 2'b00, 1, 0, 32'h0,   32'h80,  32'h0,        32'h12345678, 0, 1, 32'h80,  2, 32'h0,        0, 32'h0));
      tbl.push_back(mk(0, 1, 2'b10, 1, 0, 32'h0,   32'h102, 32'h0,        32'h87654321, 1, 0, 32'h102, 1, 32'h0,        1, 32'h00008765));
      tbl.push_back(mk(0, 1, 2'b10, 0, 1, 32'h100, 32'h0,   32'h0,        32'h1234F00D, 0, 0, 32'h100, 1, 32'h0,        1, 32'hFFFFF00D));
      tbl.push_back(mk(0, 1, 2'b11, 1, 0, 32'h0,   32'h201, 32'h0,        32'h11223344, 0, 0, 32'h201, 0, 32'h0,        1, 32'h00000033));
      tbl.push_back(mk(1, 0, 2'b10, 1, 0, 32'h0,   32'h10,  32'hABCD1234, 32'h0,        1, 0, 32'h10,  1, 32'h12341234, 0, 32'h0));
      tbl.push_back(mk(1, 1, 2'b11, 1, 0, 32'h0,   32'h43,  32'h5A,       32'hAB000000, 1, 0, 32'h43,  0, 32'h5A5A5A5A, 1, 32'h000000AB));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 32'h0,   32'h0,   32'h0,        32'h0,        0, 0, 32'h0,   2, 32'h0,        0, 32'h0));
      tbl.push_back(mk(0, 1, 2'b00, 1, 1, 32'h0,   32'h8,   32'h0,        32'h80000000, 0, 0, 32'h8,   2, 32'h0,        1, 32'h80000000));
      tbl.push_back(mk(0, 1, 2'b01, 1, 0, 32'h0,   32'h20,  32'h0,        32'h12345678, 0, 0, 32'h20,  2, 32'h0,        1, 32'h12345678));
      tbl.push_back(mk(1, 1, 2'b00, 1, 0, 32'h0,   32'h60,  32'h33,       32'h0,        1, 1, 32'h60,  2, 32'h33,       0, 32'h0));
`ifndef AHB_LSU_ALIGN_CHECK_EN
      tbl.push_back(mk(0, 1, 2'b00, 1, 0, 32'h0,   32'h102, 32'h0,        32'hCAFEF00D, 0, 0, 32'h102, 2, 32'h0,        1, 32'hCAFEF00D));
`endif
      for (int i = 0; i < tbl.size(); i++) txn(tbl[i]);

      // Reset while the data phase is stalled: no writeback, bus back to idle.
      req_wr = 1'b0; req_rd = 1'b1; req_size = 2'b00; req_pre = 1'b1;
      req_addr_calc = 32'h300; req_rd_id = 5'd9; req_valid = 1'b1; HREADY = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      HREADY = 1'b0;
      @(negedge clk);
      check("rstm_in_data", HTRANS, 0);
      check("rstm_busy", req_ready, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; HREADY = 1'b1; HRDATA = 32'h55555555;
      @(negedge clk);
      check("rstm_htrans", HTRANS, 0);
      check("rstm_ready", req_ready, 1);
      check("rstm_wb", wb_valid, 0);
      check("rstm_abort", abort, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstm_wb_later", wb_valid, 0);
      check("rstm_htrans_later", HTRANS, 0);
      @(posedge clk); #1;

`ifdef AHB_LSU_ALIGN_CHECK_EN
      req_wr = 1'b0; req_rd = 1'b1; req_size = 2'b00; req_pre = 1'b1;
      req_addr_calc = 32'h102; req_valid = 1'b1; HREADY = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("mis_abort", abort, 1);
      check("mis_htrans", HTRANS, 0);
      check("mis_busy", req_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("mis_abort_pulse", abort, 0);
      check("mis_ready", req_ready, 1);
      check("mis_htrans2", HTRANS, 0);
      check("mis_no_wb", wb_valid, 0);
      @(posedge clk); #1;
      HREADY = 1'b1;
`endif

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         v.wr = (op != 0);
         v.rd = (op != 1);
         case ($urandom_range(0, 3))
            0: v.size = 2'b00;
            1: v.size = 2'b01;
            2: v.size = 2'b10;
            default: v.size = 2'b11;
         endcase
         a = $urandom & 32'hFFFF_FFFC;
         if (v.size == 2'b11)      a = a | 32'($urandom_range(0, 3));
         else if (v.size == 2'b10) a = a | (32'($urandom_range(0, 1)) << 1);
         v.pre  = $urandom_range(0, 1);
         v.sext = (op == 0) ? bit'($urandom_range(0, 1)) : 1'b0;
         v.base = v.pre ? $urandom : a;
         v.calc = v.pre ? a : $urandom;
         v.wdata = $urandom;
         v.id = 5'($urandom_range(0, 31));
         v.rdata = $urandom;
         v.ws  = $urandom_range(0, 2);
         v.ws2 = $urandom_range(0, 2);
         v.err = ($urandom_range(0, 7) == 0);
         v.exp_haddr   = a;
         v.exp_hsize   = m_hsize(v.size);
         v.exp_hwdata  = m_wbus(v.size, v.wdata);
         v.exp_wb      = !v.err && v.rd;
         v.exp_wb_data = m_load(v.size, v.sext, a, v.rdata);
         txn(v);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
